get_pins_pipeline: RTL and testbench

Parametrised successor to the two-flop get_pins test netlist. It runs LANES independent bit lanes through DEPTH handshaked register stages, with a per-lane output-polarity mask. Each storage bit is a discrete leaf flop instance, so SDC pin queries (get_pins, with and without -regexp) resolve to a predictable, scalable set of D/Q/clk/rst/en pins. Occupancy and beat-count outputs let timing-coverage benches check the pipeline's flow.

---
 rtl/get_pins_pipeline.sv | 142 ++++++++++++++
 tb/tb_get_pins_pipeline.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/get_pins_pipeline.sv
// get_pins_leaf_ff
//   One storage bit of the pipeline. It is kept as a distinct module so that
//   every data bit is a named leaf instance with a fixed pin set for SDC
//   pin queries.
//   Ports: clk (rising edge), rst (async active-high, clears Q),
//          en (load enable), D (next value), Q (stored value).
module get_pins_leaf_ff (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic D,
    output logic Q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q <= 1'b0;
        end else if (en) begin
            Q <= D;
        end
    end

endmodule

// get_pins_pipeline
//   LANES independent bit lanes pass through DEPTH valid/ready register
//   stages. Lane j is inverted at stage-0 capture when INV_MASK[j] is set.
//   Each data bit is one get_pins_leaf_ff. The instance path is
//   u_s[i].u_l[j].u_ff, and its pins are clk/rst/en/D/Q.
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     in_valid   upstream beat valid
//     in_ready   a beat can be accepted this cycle
//     data_in    upstream lane data
//     out_valid  last stage holds a beat
//     out_ready  downstream accepts the beat
//     data_out   lane data of the last stage
//     occupancy  number of valid stages (0..DEPTH)
//     beat_count beats delivered downstream, wrapping at 2^CNT_W
module get_pins_pipeline #(
    parameter int               LANES    = 2,
    parameter int               DEPTH    = 2,
    parameter logic [LANES-1:0] INV_MASK = 2'b01,
    parameter int               CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES-1:0]           data_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           beat_count
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0]            load;
    logic [DEPTH-1:0]            en;
    logic [DEPTH-1:0][LANES-1:0] q;

    // The ready chain runs from the output back to the input in one block.
    // A stage can move forward when the next stage is empty or is itself
    // moving forward, so a bubble anywhere lets the stages above it collapse.
    always_comb begin
        adv  = '0;
        load = '0;
        en   = '0;
        adv[DEPTH-1] = vld[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = vld[i] & (~vld[i+1] | adv[i+1]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            load[i] = ~vld[i] | adv[i];
        end
        // Data flops only load when a real beat arrives, so bubbles and X on
        // idle inputs never disturb stored bits.
        en[0] = load[0] & in_valid;
        for (int i = 1; i < DEPTH; i++) begin
            en[i] = load[i] & vld[i-1];
        end
    end

    // Stage boundary: valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[0] <= (in_valid & load[0]) | (vld[0] & ~adv[0]);
            for (int i = 1; i < DEPTH; i++) begin
                if (load[i]) begin
                    vld[i] <= adv[i-1];
                end
            end
        end
    end

    // Stage boundary: data bits, one leaf flop per stage and lane
    for (genvar i = 0; i < DEPTH; i++) begin : u_s
        logic [LANES-1:0] src;
        if (i == 0) begin : g_src_in
            assign src = data_in ^ INV_MASK;
        end else begin : g_src_stage
            assign src = q[i-1];
        end
        for (genvar j = 0; j < LANES; j++) begin : u_l
            get_pins_leaf_ff u_ff (
                .clk (clk),
                .rst (rst),
                .en  (en[i]),
                .D   (src[j]),
                .Q   (q[i][j])
            );
        end
    end

    // Stage boundary: delivered-beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count <= '0;
        end else if (adv[DEPTH-1]) begin
            beat_count <= beat_count + 1'b1;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(vld[i]);
        end
    end

    assign in_ready  = load[0];
    assign out_valid = vld[DEPTH-1];
    assign data_out  = q[DEPTH-1];

endmodule

// File: tb/tb_get_pins_pipeline.sv
module tb_get_pins_pipeline;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: LANES=2 DEPTH=2 INV=01 CNT_W=8
    logic       rst_a, iv_a, ir_a, ov_a, or_a;
    logic [1:0] di_a, do_a, occ_a;
    logic [7:0] bc_a;
    get_pins_pipeline #(.LANES(2), .DEPTH(2), .INV_MASK(2'b01), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst_a), .in_valid(iv_a), .in_ready(ir_a), .data_in(di_a),
        .out_valid(ov_a), .out_ready(or_a), .data_out(do_a), .occupancy(occ_a), .beat_count(bc_a));

    // DUT B: LANES=4 DEPTH=3 INV=0110 CNT_W=8
    localparam logic [3:0] INV_B = 4'b0110;
    logic       rst_b, iv_b, ir_b, ov_b, or_b;
    logic [3:0] di_b, do_b;
    logic [1:0] occ_b;
    logic [7:0] bc_b;
    get_pins_pipeline #(.LANES(4), .DEPTH(3), .INV_MASK(INV_B), .CNT_W(8)) u_dut_b (
        .clk(clk), .rst(rst_b), .in_valid(iv_b), .in_ready(ir_b), .data_in(di_b),
        .out_valid(ov_b), .out_ready(or_b), .data_out(do_b), .occupancy(occ_b), .beat_count(bc_b));

    // DUT C: LANES=2 DEPTH=4 INV=01 CNT_W=8
    logic       rst_c, iv_c, ir_c, ov_c, or_c;
    logic [1:0] di_c, do_c;
    logic [2:0] occ_c;
    logic [7:0] bc_c;
    get_pins_pipeline #(.LANES(2), .DEPTH(4), .INV_MASK(2'b01), .CNT_W(8)) u_dut_c (
        .clk(clk), .rst(rst_c), .in_valid(iv_c), .in_ready(ir_c), .data_in(di_c),
        .out_valid(ov_c), .out_ready(or_c), .data_out(do_c), .occupancy(occ_c), .beat_count(bc_c));

    // DUT D: LANES=2 DEPTH=1 INV=01 CNT_W=3
    logic       rst_d, iv_d, ir_d, ov_d, or_d;
    logic [1:0] di_d, do_d;
    logic       occ_d;
    logic [2:0] bc_d;
    get_pins_pipeline #(.LANES(2), .DEPTH(1), .INV_MASK(2'b01), .CNT_W(3)) u_dut_d (
        .clk(clk), .rst(rst_d), .in_valid(iv_d), .in_ready(ir_d), .data_in(di_d),
        .out_valid(ov_d), .out_ready(or_d), .data_out(do_d), .occupancy(occ_d), .beat_count(bc_d));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] sdat(int k);
        return 4'((k * 3 + 1) & 15);
    endfunction

    task automatic test_reset;
        // Initial reset: outputs are defined while rst is high.
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL rst0_out_valid got=%b exp=0", ov_a); end
        checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL rst0_in_ready got=%b exp=1", ir_a); end
        checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL rst0_occupancy got=%0d exp=0", occ_a); end
        tick; tick;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        // Two beats in flight, then reset without any clock edge.
        or_a = 1'b0; iv_a = 1'b1; di_a = 2'b11;
        tick;
        di_a = 2'b00;
        tick;
        iv_a = 1'b0;
        checks++; if (occ_a !== 2'd2) begin errors++; $display("FAIL prerst_occupancy got=%0d exp=2", occ_a); end
        #2;
        rst_a = 1'b1;
        #1;
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", ov_a); end
        checks++; if (do_a !== 2'b00) begin errors++; $display("FAIL rst_data_out got=%b exp=00", do_a); end
        checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL rst_occupancy got=%0d exp=0", occ_a); end
        checks++; if (bc_a !== 8'd0) begin errors++; $display("FAIL rst_beat_count got=%0d exp=0", bc_a); end
        checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", ir_a); end
        tick;
        rst_a = 1'b0;
        tick;
    endtask

    task automatic test_single;
        or_a = 1'b1; iv_a = 1'b1; di_a = 2'b11;
        #1;
        checks++; if (ir_a !== 1'b1) begin errors++; $display("FAIL single_in_ready got=%b exp=1", ir_a); end
        tick;
        iv_a = 1'b0;
        checks++; if (occ_a !== 2'd1) begin errors++; $display("FAIL single_occ_acc got=%0d exp=1", occ_a); end
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL single_ov_acc got=%b exp=0", ov_a); end
        tick;
        checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%b exp=1", ov_a); end
        checks++; if (do_a !== 2'b10) begin errors++; $display("FAIL single_data_out got=%b exp=10", do_a); end
        checks++; if (occ_a !== 2'd1) begin errors++; $display("FAIL single_occ_out got=%0d exp=1", occ_a); end
        tick;
        checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL single_occ_done got=%0d exp=0", occ_a); end
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL single_ov_done got=%b exp=0", ov_a); end
        checks++; if (bc_a !== 8'd1) begin errors++; $display("FAIL single_beat_count got=%0d exp=1", bc_a); end
        // Idle input carrying X must not reach any stored bit.
        di_a = 2'bxx;
        tick; tick; tick;
        checks++; if (do_a !== 2'b10) begin errors++; $display("FAIL xidle_data_out got=%b exp=10", do_a); end
        checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL xidle_occupancy got=%0d exp=0", occ_a); end
        di_a = 2'b00;
    endtask

    task automatic test_stream;
        or_b = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (c < 20) begin
                iv_b = 1'b1; di_b = sdat(c);
            end else begin
                iv_b = 1'b0; di_b = 4'h0;
            end
            #1;
            checks++; if (ir_b !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, ir_b); end
            tick;
            if (c < 2) begin
                checks++; if (ov_b !== 1'b0) begin errors++; $display("FAIL stream_fill_ov c=%0d got=%b exp=0", c, ov_b); end
            end else begin
                checks++; if (ov_b !== 1'b1 || do_b !== (sdat(c - 2) ^ INV_B)) begin
                    errors++; $display("FAIL stream_beat c=%0d got=%b/%h exp=1/%h", c, ov_b, do_b, sdat(c - 2) ^ INV_B);
                end
            end
        end
        tick;
        checks++; if (bc_b !== 8'd20) begin errors++; $display("FAIL stream_beat_count got=%0d exp=20", bc_b); end
        checks++; if (ov_b !== 1'b0) begin errors++; $display("FAIL stream_drained_ov got=%b exp=0", ov_b); end
    endtask

    task automatic test_backpressure;
        or_b = 1'b0;
        iv_b = 1'b1; di_b = 4'hA; tick;
        di_b = 4'h5; tick;
        di_b = 4'hC; tick;
        di_b = 4'h3;
        #1;
        checks++; if (occ_b !== 2'd3) begin errors++; $display("FAIL bp_occupancy got=%0d exp=3", occ_b); end
        checks++; if (ir_b !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", ir_b); end
        checks++; if (do_b !== 4'hC) begin errors++; $display("FAIL bp_data_out got=%h exp=c", do_b); end
        tick; tick;
        checks++; if (do_b !== 4'hC || ov_b !== 1'b1) begin errors++; $display("FAIL bp_hold got=%b/%h exp=1/c", ov_b, do_b); end
        checks++; if (occ_b !== 2'd3) begin errors++; $display("FAIL bp_hold_occ got=%0d exp=3", occ_b); end
        or_b = 1'b1;
        #1;
        checks++; if (ir_b !== 1'b1) begin errors++; $display("FAIL bp_pushpop_ready got=%b exp=1", ir_b); end
        tick;
        iv_b = 1'b0;
        checks++; if (occ_b !== 2'd3) begin errors++; $display("FAIL bp_pushpop_occ got=%0d exp=3", occ_b); end
        checks++; if (do_b !== 4'h3) begin errors++; $display("FAIL bp_pushpop_data got=%h exp=3", do_b); end
        checks++; if (bc_b !== 8'd21) begin errors++; $display("FAIL bp_pushpop_count got=%0d exp=21", bc_b); end
        tick;
        checks++; if (do_b !== 4'hA || occ_b !== 2'd2) begin errors++; $display("FAIL bp_drain1 got=%h/%0d exp=a/2", do_b, occ_b); end
        tick;
        checks++; if (do_b !== 4'h5 || occ_b !== 2'd1) begin errors++; $display("FAIL bp_drain2 got=%h/%0d exp=5/1", do_b, occ_b); end
        tick;
        checks++; if (ov_b !== 1'b0 || bc_b !== 8'd24) begin errors++; $display("FAIL bp_drained got=%b/%0d exp=0/24", ov_b, bc_b); end
    endtask

    task automatic test_bubble;
        or_c = 1'b0;
        for (int k = 0; k < 4; k++) begin
            iv_c = 1'b1; di_c = 2'(k);
            tick;
        end
        iv_c = 1'b0;
        #1;
        checks++; if (occ_c !== 3'd4) begin errors++; $display("FAIL bub_full_occ got=%0d exp=4", occ_c); end
        checks++; if (ir_c !== 1'b0) begin errors++; $display("FAIL bub_full_ready got=%b exp=0", ir_c); end
        checks++; if (do_c !== 2'b01) begin errors++; $display("FAIL bub_full_data got=%b exp=01", do_c); end
        or_c = 1'b1;
        #1;
        checks++; if (ir_c !== 1'b1) begin errors++; $display("FAIL bub_ready_same_cycle got=%b exp=1", ir_c); end
        tick;
        or_c = 1'b0;
        checks++; if (occ_c !== 3'd3) begin errors++; $display("FAIL bub_pop_occ got=%0d exp=3", occ_c); end
        checks++; if (do_c !== 2'b00) begin errors++; $display("FAIL bub_pop_data got=%b exp=00", do_c); end
        checks++; if (ir_c !== 1'b1) begin errors++; $display("FAIL bub_pop_ready got=%b exp=1", ir_c); end
        iv_c = 1'b1; di_c = 2'b10;
        tick;
        iv_c = 1'b0;
        checks++; if (occ_c !== 3'd4) begin errors++; $display("FAIL bub_refill_occ got=%0d exp=4", occ_c); end
        or_c = 1'b1;
        tick;
        checks++; if (do_c !== 2'b11) begin errors++; $display("FAIL bub_order1 got=%b exp=11", do_c); end
        tick;
        checks++; if (do_c !== 2'b10) begin errors++; $display("FAIL bub_order2 got=%b exp=10", do_c); end
        tick;
        checks++; if (do_c !== 2'b11 || ov_c !== 1'b1) begin errors++; $display("FAIL bub_order3 got=%b/%b exp=1/11", ov_c, do_c); end
        tick;
        checks++; if (ov_c !== 1'b0 || bc_c !== 8'd5) begin errors++; $display("FAIL bub_drained got=%b/%0d exp=0/5", ov_c, bc_c); end
    endtask

    task automatic test_wrap;
        or_d = 1'b1;
        for (int k = 0; k < 9; k++) begin
            iv_d = 1'b1; di_d = 2'(k);
            #1;
            checks++; if (ir_d !== 1'b1) begin errors++; $display("FAIL wrap_in_ready k=%0d got=%b exp=1", k, ir_d); end
            tick;
            checks++; if (ov_d !== 1'b1 || do_d !== (2'(k) ^ 2'b01)) begin
                errors++; $display("FAIL wrap_beat k=%0d got=%b/%b exp=1/%b", k, ov_d, do_d, 2'(k) ^ 2'b01);
            end
            checks++; if (bc_d !== 3'(k)) begin errors++; $display("FAIL wrap_count k=%0d got=%0d exp=%0d", k, bc_d, 3'(k)); end
        end
        iv_d = 1'b0;
        tick;
        checks++; if (bc_d !== 3'd1) begin errors++; $display("FAIL wrap_final got=%0d exp=1", bc_d); end
        checks++; if (ov_d !== 1'b0 || occ_d !== 1'b0) begin errors++; $display("FAIL wrap_empty got=%b/%b exp=0/0", ov_d, occ_d); end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0; iv_d = 1'b0;
        or_a = 1'b0; or_b = 1'b0; or_c = 1'b0; or_d = 1'b0;
        di_a = '0; di_b = '0; di_c = '0; di_d = '0;
        #2;
        test_reset;
        test_single;
        test_stream;
        test_backpressure;
        test_bubble;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
